// File: rtl/bcd_converter.sv
// bcd_converter: sequential double-dabble binary-to-packed-BCD converter, one bit per cycle.
// Optional BCD_ASCII_EN adds an ascii output with leading-zero blanking.
module bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  in_Clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_ASCII_EN
    ,
    output logic [8*DIGITS-1:0]   ascii
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  bin_sr, bin_sr_n;
    logic [BW-1:0]     bcd_sr, bcd_sr_n, corr, bcd_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              busy_n, done_n;
    logic [BW+WIDTH-1:0] sh;

`ifdef BCD_ASCII_EN
    logic [8*DIGITS-1:0] ascii_n;

    function automatic logic [8*DIGITS-1:0] to_ascii(input logic [BW-1:0] v);
        logic lead;
        to_ascii = '0;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (lead && i != 0 && v[4*i+:4] == 4'd0) begin
                to_ascii[8*i+:8] = 8'h20;
            end else begin
                to_ascii[8*i+:8] = 8'h30 + {4'h0, v[4*i+:4]};
                lead = 1'b0;
            end
        end
    endfunction
`endif

    always_comb begin
        corr = bcd_sr;
        for (int d = 0; d < DIGITS; d++)
            corr[4*d+:4] = (bcd_sr[4*d+:4] >= 4'd5) ? bcd_sr[4*d+:4] + 4'd3 : bcd_sr[4*d+:4];
        sh = {corr, bin_sr} << 1;
        state_n  = state;
        bin_sr_n = bin_sr;
        bcd_sr_n = bcd_sr;
        cnt_n    = cnt;
        busy_n   = busy;
        done_n   = 1'b0;
        bcd_n    = bcd;
        case (state)
            IDLE: if (start) begin
                bin_sr_n = bin;
                bcd_sr_n = '0;
                cnt_n    = '0;
                busy_n   = 1'b1;
                state_n  = SHIFT;
            end
            SHIFT: begin
                bin_sr_n = sh[WIDTH-1:0];
                bcd_sr_n = sh[BW+WIDTH-1:WIDTH];
                cnt_n    = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    bcd_n   = sh[BW+WIDTH-1:WIDTH];
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef BCD_ASCII_EN
        ascii_n = done_n ? to_ascii(bcd_n) : ascii;
`endif
    end

    always_ff @(posedge in_Clk) begin
        if (reset) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
`ifdef BCD_ASCII_EN
            ascii  <= to_ascii('0);
`endif
        end else begin
            state  <= state_n;
            bin_sr <= bin_sr_n;
            bcd_sr <= bcd_sr_n;
            cnt    <= cnt_n;
            busy   <= busy_n;
            done   <= done_n;
            bcd    <= bcd_n;
`ifdef BCD_ASCII_EN
            ascii  <= ascii_n;
`endif
        end
    end
endmodule
